div_unit: RTL and testbench

Iterative 32-bit MIPS DIV/DIVU unit in the EX stage. It accepts operands from the ID/EX pipeline register, holds the pipeline with a stall signal while it iterates, and delivers quotient (LO) and remainder (HI) to the HI/LO write path. The stall signal drives the enable and clear inputs of the IF/ID, ID/EX and EX/MEM pipeline registers through the hazard unit.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring radix-2 division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // Shift carries one extra bit so the trial difference sign is never lost
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;

    // Shift {rem,quo} left, trial-subtract, keep the difference when non-negative
    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        diff   = rem_sh - {2'b00, divisor_i};
        if (!diff[WIDTH+1]) begin
            rem_o = diff[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit MIPS DIV/DIVU unit with pipeline stall
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] a_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             dz_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             take;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_nx),
        .quo_o     (quo_nx)
    );

    // Operand magnitudes; 0x80000000 negates to itself, which reads as 2^31 unsigned
    always_comb begin
        mag_a = (signed_div && a[WIDTH-1]) ? -a : a;
        mag_b = (signed_div && b[WIDTH-1]) ? -b : b;
        take  = (state_q == IDLE) && start && !cancel;
    end

    // Final sign correction, with divide-by-zero overriding the computed result
    always_comb begin
        res_lo = sign_q_q ? -quo_q : quo_q;
        res_hi = sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        if (dz_q) begin
            res_lo = '1;
            res_hi = a_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; cancel returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = DIV;
                DIV:     if (cnt_q == LAST_STEP) state_d = SIGN;
                SIGN:    state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs; stall drops in DONE so EX advances alongside the valid pulse
    always_comb begin
        stall = take || (state_q == DIV) || (state_q == SIGN);
        valid = (state_q == DONE);
    end

    // Operand latches, iteration datapath and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            a_q      <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else if (!cancel) begin
            case (state_q)
                IDLE: if (start) begin
                    cnt_q    <= '0;
                    rem_q    <= '0;
                    quo_q    <= mag_a;
                    dvs_q    <= mag_b;
                    a_q      <= a;
                    sign_q_q <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_r_q <= signed_div && a[WIDTH-1];
                    dz_q     <= (b == '0);
                end
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                SIGN: begin
                    lo_q <= res_lo;
                    hi_q <= res_hi;
                end
                default: ;
            endcase
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic model
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        stall;
    logic        valid;
    logic [31:0] lo;
    logic [31:0] hi;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_lo = 32'h0;
    logic [31:0] exp_hi = 32'h0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .stall      (stall),
        .valid      (valid),
        .lo         (lo),
        .hi         (hi)
    );

    always #5 clk = ~clk;

    function automatic void model(input bit sd, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] lo_e, output logic [31:0] hi_e);
        longint sa, sb, q, r;
        if (bv == 32'h0) begin
            lo_e = 32'hFFFF_FFFF;
            hi_e = av;
        end else if (sd) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = sa / sb;
            r  = sa % sb;
            lo_e = q[31:0];
            hi_e = r[31:0];
        end else begin
            lo_e = av / bv;
            hi_e = av % bv;
        end
    endfunction

    // Issues one divide and watches it to completion; poke re-asserts start mid-divide
    task automatic run_div(input string name, input bit sd, input logic [31:0] av,
                           input logic [31:0] bv, input int poke);
        int lat;
        int stall_bad;
        logic [31:0] got_lo, got_hi;
        lat = -1;
        stall_bad = 0;
        got_lo = 32'h0;
        got_hi = 32'h0;
        model(sd, av, bv, exp_lo, exp_hi);
        @(negedge clk);
        signed_div = sd; a = av; b = bv; start = 1'b1; cancel = 1'b0;
        #1 if (!stall) stall_bad++;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (k == poke) begin
                start = 1'b1; a = ~av; b = bv + 32'd3; signed_div = ~sd;
            end else begin
                start = 1'b0;
            end
            #1;
            if (valid) begin
                lat = k;
                got_lo = lo;
                got_hi = hi;
                if (stall) stall_bad++;
            end else if (!stall) begin
                stall_bad++;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (lat !== 34) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected 34", name, lat);
        end
        n_cmp++;
        if (got_lo !== exp_lo) begin
            n_err++;
            $display("FAIL %s lo: got %h expected %h", name, got_lo, exp_lo);
        end
        n_cmp++;
        if (got_hi !== exp_hi) begin
            n_err++;
            $display("FAIL %s hi: got %h expected %h", name, got_hi, exp_hi);
        end
        n_cmp++;
        if (stall_bad !== 0) begin
            n_err++;
            $display("FAIL %s stall: got %0d bad cycles expected 0", name, stall_bad);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({lo, hi, valid, stall} !== 66'h0) begin
            n_err++;
            $display("FAIL reset: got lo=%h hi=%h valid=%b stall=%b expected zeros", lo, hi, valid, stall);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got stall=%b valid=%b expected 0 0", stall, valid);
        end
    endtask

    task automatic test_directed();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div("div_dz", 1'b1, 32'd5, 32'd0, 0);
        run_div("divu_dz", 1'b0, 32'd5, 32'd0, 0);
        run_div("div_dz_neg", 1'b1, 32'hFFFF_FFF0, 32'd0, 0);
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(1, 15);
                1:       rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_div("random", 1'($urandom_range(0, 1)), ra, rb, 0);
        end
    endtask

    task automatic test_cancel();
        int seen;
        seen = 0;
        @(negedge clk);
        signed_div = 1'b0; a = 32'd1000; b = 32'd9; start = 1'b1; cancel = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start  = 1'b0;
            cancel = (k == 10);
            #1;
            if (valid) seen++;
            if (k == 11) begin
                n_cmp++;
                if (stall !== 1'b0) begin
                    n_err++;
                    $display("FAIL cancel_idle: got stall=%b expected 0", stall);
                end
            end
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL cancel_valid: got %0d pulses expected 0", seen);
        end
        n_cmp++;
        if (lo !== exp_lo || hi !== exp_hi) begin
            n_err++;
            $display("FAIL cancel_hold: got %h/%h expected %h/%h", lo, hi, exp_lo, exp_hi);
        end
        run_div("after_cancel", 1'b1, 32'hFFFF_FC00, 32'd7, 0);
    endtask

    task automatic test_start_cancel();
        int seen;
        seen = 0;
        @(negedge clk);
        signed_div = 1'b0; a = 32'd50; b = 32'd3; start = 1'b1; cancel = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL start_cancel_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (valid || stall) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL start_cancel_busy: got %0d busy cycles expected 0", seen);
        end
    endtask

    task automatic test_start_during_div();
        run_div("start_in_div", 1'b1, 32'h1234_5678, 32'hFFFF_FF00, 5);
        run_div("start_in_done", 1'b0, 32'hDEAD_BEEF, 32'd77, 34);
    endtask

    task automatic test_back_to_back();
        run_div("b2b_0", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div("b2b_1", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        run_div("b2b_2", 1'b1, 32'h8000_0000, 32'd2, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        signed_div = 1'b0; a = 32'd999; b = 32'd4; start = 1'b1; cancel = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        exp_lo = 32'h0;
        exp_hi = 32'h0;
        n_cmp++;
        if (lo !== exp_lo || hi !== exp_hi || valid !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got lo=%h hi=%h valid=%b stall=%b expected zeros", lo, hi, valid, stall);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_div("after_reset", 1'b1, 32'd12345, 32'hFFFF_FFF3, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_start_cancel();
        test_start_during_div();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
